// File: rtl/text_overlay_renderer.sv
// text_overlay_renderer: slides a bitmap message vertically into its rest
// position, then blinks it, producing a box flag and a lit-pixel flag for the
// current scan coordinate through a two-stage pipeline.
module text_overlay_renderer #(
    parameter int TEXT_W       = 104,
    parameter int TEXT_H       = 11,
    parameter int SCALE        = 3,
    parameter int MSG_X        = 180,
    parameter int MSG_Y        = 180,
    parameter int NUM_MSG      = 2,
    parameter logic [NUM_MSG*TEXT_W*TEXT_H-1:0] BITMAP = '0,
    parameter int SLIDE_PIX    = 60,
    parameter int SLIDE_STEP   = 4,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] X,
    input  logic [9:0] Y,
    input  logic       frame_start,
    input  logic       enable,
    input  logic [((NUM_MSG > 1) ? $clog2(NUM_MSG) : 1)-1:0] msg_sel,
    output logic       inside_area,
    output logic       is_pixel
);

    localparam int SEL_W    = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
    localparam int ROW_W    = (TEXT_H > 1) ? $clog2(TEXT_H) : 1;
    localparam int COL_W    = (TEXT_W > 1) ? $clog2(TEXT_W) : 1;
    localparam int CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    // Coordinates are widened so box edges past 1023 never wrap; the 10-bit
    // scan position then clips the box naturally.
    localparam int CW       = 12;
    localparam int MSG_BITS = TEXT_W * TEXT_H;
    localparam int IDX_W    = (NUM_MSG * MSG_BITS > 1) ? $clog2(NUM_MSG * MSG_BITS) : 1;

    localparam logic [SEL_W-1:0] MSG_LAST = SEL_W'(NUM_MSG - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (BLINK_FRAMES > 0) ? CNT_W'(BLINK_FRAMES - 1) : '0;

    typedef enum logic [1:0] {IDLE, SLIDE, ON, OFF} state_t;

    state_t            state;
    logic [CW-1:0]     offset;
    logic [CNT_W-1:0]  blink_cnt;
    logic [SEL_W-1:0]  msg;

    logic [CW-1:0]     x_ext, y_ext, top, dx, dy;
    logic              in_box;

    logic              s1_in;
    logic [ROW_W-1:0]  s1_row;
    logic [COL_W-1:0]  s1_col;
    state_t            s1_state;
    logic [SEL_W-1:0]  s1_msg;

    logic [IDX_W-1:0]  bit_idx;
    logic              lit;

    // Frame-rate control: slide-in, blink and message latch, advanced only on frame_start
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            offset    <= '0;
            blink_cnt <= '0;
            msg       <= '0;
        end else if (frame_start) begin
            if (!enable) begin
                state  <= IDLE;
                offset <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state     <= SLIDE;
                        offset    <= CW'(SLIDE_PIX);
                        blink_cnt <= '0;
                        msg       <= (msg_sel > MSG_LAST) ? MSG_LAST : msg_sel;
                    end
                    SLIDE: begin
                        if (offset == '0)
                            state <= ON;
                        else if (offset > CW'(SLIDE_STEP))
                            offset <= offset - CW'(SLIDE_STEP);
                        else
                            offset <= '0;
                    end
                    ON, OFF: begin
                        if (BLINK_FRAMES == 0) begin
                            state <= ON;
                        end else if (blink_cnt == CNT_LAST) begin
                            state     <= (state == ON) ? OFF : ON;
                            blink_cnt <= '0;
                        end else begin
                            blink_cnt <= blink_cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Box test against the pre-update offset for the current scan position
    always_comb begin
        x_ext  = CW'(X);
        y_ext  = CW'(Y);
        top    = CW'(MSG_Y) + offset;
        dx     = x_ext - CW'(MSG_X);
        dy     = y_ext - top;
        in_box = (x_ext >= CW'(MSG_X)) && (x_ext < CW'(MSG_X + TEXT_W * SCALE)) &&
                 (y_ext >= top) && (y_ext < top + CW'(TEXT_H * SCALE));
    end

    // Stage 1: register box flag, source row/column, state and message
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_in    <= 1'b0;
            s1_row   <= '0;
            s1_col   <= '0;
            s1_state <= IDLE;
            s1_msg   <= '0;
        end else begin
            s1_in    <= in_box;
            s1_row   <= in_box ? ROW_W'(dy / CW'(SCALE)) : '0;
            s1_col   <= in_box ? COL_W'(dx / CW'(SCALE)) : '0;
            s1_state <= state;
            s1_msg   <= msg;
        end
    end

    // Bitmap is stored top row / leftmost column in the most significant bits
    always_comb begin
        bit_idx = IDX_W'(int'(s1_msg) * MSG_BITS
                         + (TEXT_H - 1 - int'(s1_row)) * TEXT_W
                         + (TEXT_W - 1 - int'(s1_col)));
        lit     = BITMAP[bit_idx];
    end

    // Stage 2: register gated outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            inside_area <= 1'b0;
            is_pixel    <= 1'b0;
        end else begin
            inside_area <= s1_in && (s1_state != IDLE);
            is_pixel    <= s1_in && ((s1_state == SLIDE) || (s1_state == ON)) && lit;
        end
    end

endmodule
